// File: rtl/fifo_burst_reader_if.sv
// rtl/fifo_burst_reader_if.sv - FIFO read port and output stream bundle for fifo_burst_reader
interface fifo_burst_reader_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic             fifo_r_en;
    logic [WIDTH-1:0] fifo_rdata;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  m_ready,
        output fifo_r_en,
        output m_valid,
        output m_data,
        output m_last
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output m_ready,
        input  fifo_r_en,
        input  m_valid,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - pops len words from the dual-clock FIFO read port onto a valid/ready stream
// Optional blocked-read counter output underrun_cnt under FIFO_BURST_RD_UNDERRUN_CNT_EN.
module fifo_burst_reader #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    output logic                busy,
    output logic                done,
`ifdef FIFO_BURST_RD_UNDERRUN_CNT_EN
    output logic [15:0]         underrun_cnt,
`endif
    fifo_burst_reader_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issued_q;
    logic [LEN_W-1:0] delivered_q;
    logic             inflight_q;
    logic [1:0]       occ_q;
    logic [WIDTH-1:0] slot_q [3];
    logic [1:0]       wr_ptr_q;
    logic [1:0]       rd_ptr_q;
    logic             done_q;
    logic             done_d;
    logic             rd_en;

    logic             room;
    logic             want;
    logic             push;
    logic             pop;
    logic             accept;
    logic             zero_req;
    logic             last_beat;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credits: words already buffered plus the one possibly returning from the FIFO.
    assign room      = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3;
    assign want      = issued_q < len_q;
    assign push      = inflight_q;
    assign pop       = bus.m_valid && bus.m_ready;
    assign accept    = (state_q == ST_IDLE) && start && (len != '0);
    assign zero_req  = (state_q == ST_IDLE) && start && (len == '0);
    assign last_beat = pop && (delivered_q == len_q - ONE);

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                end
                if (zero_req) begin
                    done_d = 1'b1;
                end
            end
            ST_RUN: begin
                rd_en = !bus.fifo_empty && want && room;
                if (rd_en && (issued_q + ONE == len_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_beat) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            slot_q[0]   <= '0;
            slot_q[1]   <= '0;
            slot_q[2]   <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            inflight_q <= rd_en;

            if (accept) begin
                len_q       <= len;
                issued_q    <= '0;
                delivered_q <= '0;
            end else begin
                if (rd_en) begin
                    issued_q <= issued_q + ONE;
                end
                if (pop) begin
                    delivered_q <= delivered_q + ONE;
                end
            end

            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase

            if (push) begin
                slot_q[wr_ptr_q] <= bus.fifo_rdata;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign bus.fifo_r_en = rd_en;
    assign bus.m_valid   = (occ_q != 2'd0);
    assign bus.m_data    = slot_q[rd_ptr_q];
    assign bus.m_last    = bus.m_valid && (delivered_q == len_q - ONE);

`ifdef FIFO_BURST_RD_UNDERRUN_CNT_EN
    logic [15:0] underrun_q;
    logic        blocked;

    // A read that only the empty flag held back.
    assign blocked = (state_q == ST_RUN) && want && room && bus.fifo_empty;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            underrun_q <= 16'h0000;
        end else if ((state_q == ST_IDLE) && start) begin
            underrun_q <= 16'h0000;
        end else if (blocked && (underrun_q != 16'hFFFF)) begin
            underrun_q <= underrun_q + 16'h0001;
        end
    end

    assign underrun_cnt = underrun_q;
`endif

    a_no_overflow: assert property (@(posedge rclk) disable iff (rrst)
        ({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd3);

    a_no_full_push: assert property (@(posedge rclk) disable iff (rrst)
        !(push && !pop && (occ_q == 2'd3)));

endmodule
